// File: rtl/mem_stage_pkg.sv
// Shared constants for the memory-access stage: opcodes, access sizes and FSM states.
package mem_stage_pkg;

  localparam logic [6:0] LOAD_OPCODE  = 7'b0000011;
  localparam logic [6:0] STORE_OPCODE = 7'b0100011;
  localparam logic [6:0] RTYPE_OPCODE = 7'b0110011;
  localparam logic [6:0] ITYPE_OPCODE = 7'b0010011;
  localparam logic [6:0] LUI_OPCODE   = 7'b0110111;
  localparam logic [6:0] AUIPC_OPCODE = 7'b0010111;
  localparam logic [6:0] JAL_OPCODE   = 7'b1101111;
  localparam logic [6:0] JALR_OPCODE  = 7'b1100111;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } mem_state_e;

  // Non-memory opcodes that produce a register result.
  function automatic logic writes_rd(input logic [6:0] op);
    return (op == RTYPE_OPCODE) || (op == ITYPE_OPCODE) ||
           (op == LUI_OPCODE)   || (op == AUIPC_OPCODE) ||
           (op == JAL_OPCODE)   || (op == JALR_OPCODE);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response port between the memory stage (master) and the memory (slave).
interface mem_stage_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_stage_lane_align.sv
// Combinational lane logic: store byte-enable/data steering, load lane extraction with
// sign/zero extension, and misalignment (including illegal size) detection.
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic [1:0]        addr_i,
  input  logic [2:0]        funct3_i,
  input  logic              is_store_i,
  input  logic [DWIDTH-1:0] rs2_i,
  input  logic [DWIDTH-1:0] rdata_i,
  output logic [3:0]        be_o,
  output logic [DWIDTH-1:0] wdata_o,
  output logic [DWIDTH-1:0] ld_data_o,
  output logic              misalign_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata_i[{addr_i, 3'b000} +: 8];
  assign half_v = rdata_i[{addr_i[1], 4'b0000} +: 16];

  always_comb begin
    misalign_o = 1'b1;
    ld_data_o  = '0;
    unique case (funct3_i)
      FUNCT3_B: begin
        misalign_o = 1'b0;
        ld_data_o  = {{(DWIDTH-8){byte_v[7]}}, byte_v};
      end
      FUNCT3_BU: begin
        misalign_o = 1'b0;
        ld_data_o  = {{(DWIDTH-8){1'b0}}, byte_v};
      end
      FUNCT3_H: begin
        misalign_o = addr_i[0];
        ld_data_o  = {{(DWIDTH-16){half_v[15]}}, half_v};
      end
      FUNCT3_HU: begin
        misalign_o = addr_i[0];
        ld_data_o  = {{(DWIDTH-16){1'b0}}, half_v};
      end
      FUNCT3_W: begin
        misalign_o = (addr_i != 2'b00);
        ld_data_o  = rdata_i;
      end
      default: begin
        misalign_o = 1'b1;
        ld_data_o  = '0;
      end
    endcase
  end

  // Loads always fetch the full word; only stores need narrowed enables.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = '0;
    if (is_store_i) begin
      unique case (funct3_i)
        FUNCT3_B: begin
          be_o    = 4'b0001 << addr_i;
          wdata_o = {(DWIDTH/8){rs2_i[7:0]}};
        end
        FUNCT3_H: begin
          be_o    = 4'b0011 << {addr_i[1], 1'b0};
          wdata_o = {(DWIDTH/16){rs2_i[15:0]}};
        end
        FUNCT3_W: begin
          be_o    = 4'b1111;
          wdata_o = rs2_i;
        end
        default: begin
          be_o    = 4'b0000;
          wdata_o = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: takes the ALU result from execute, performs loads/stores over the
// data-memory port and hands one result per instruction to writeback.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ex_valid_i,
  output logic              ex_ready_o,
  input  logic [DWIDTH-1:0] ex_res_i,
  input  logic [DWIDTH-1:0] ex_rs2_i,
  input  logic [6:0]        ex_opcode_i,
  input  logic [2:0]        ex_funct3_i,
  input  logic [4:0]        ex_rd_i,
  input  logic [AWIDTH-1:0] ex_pc_i,
  mem_stage_if.master       dmem,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [DWIDTH-1:0] wb_data_o,
  output logic [4:0]        wb_rd_o,
  output logic              wb_we_o,
  output logic [AWIDTH-1:0] wb_pc_o,
  output logic              wb_misalign_o
);

  mem_state_e        state_q, state_d;
  logic [DWIDTH-1:0] res_q, res_d;
  logic [DWIDTH-1:0] rs2_q, rs2_d;
  logic [6:0]        opcode_q, opcode_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] wb_data_q, wb_data_d;
  logic              wb_we_q, wb_we_d;
  logic              misalign_q, misalign_d;

  logic              in_idle, in_req, is_store_q, ex_is_mem;
  logic [1:0]        al_addr;
  logic [2:0]        al_funct3;
  logic [3:0]        al_be;
  logic [DWIDTH-1:0] al_wdata, al_ld_data;
  logic              al_misalign;
  logic [AWIDTH-1:0] addr_full;

  assign in_idle    = (state_q == IDLE);
  assign in_req     = (state_q == REQ);
  assign is_store_q = (opcode_q == STORE_OPCODE);
  assign ex_is_mem  = (ex_opcode_i == LOAD_OPCODE) || (ex_opcode_i == STORE_OPCODE);

  // While idle the checker looks at the incoming instruction so misalignment is known at accept.
  assign al_addr   = in_idle ? ex_res_i[1:0] : res_q[1:0];
  assign al_funct3 = in_idle ? ex_funct3_i   : funct3_q;

  mem_lane_align #(.DWIDTH(DWIDTH)) u_align (
    .addr_i     (al_addr),
    .funct3_i   (al_funct3),
    .is_store_i (is_store_q),
    .rs2_i      (rs2_q),
    .rdata_i    (dmem.rsp_rdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .ld_data_o  (al_ld_data),
    .misalign_o (al_misalign)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      res_q      <= '0;
      rs2_q      <= '0;
      opcode_q   <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      pc_q       <= '0;
      wb_data_q  <= '0;
      wb_we_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      res_q      <= res_d;
      rs2_q      <= rs2_d;
      opcode_q   <= opcode_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      pc_q       <= pc_d;
      wb_data_q  <= wb_data_d;
      wb_we_q    <= wb_we_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    res_d      = res_q;
    rs2_d      = rs2_q;
    opcode_d   = opcode_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    pc_d       = pc_q;
    wb_data_d  = wb_data_q;
    wb_we_d    = wb_we_q;
    misalign_d = misalign_q;
    unique case (state_q)
      IDLE: begin
        if (ex_valid_i) begin
          res_d      = ex_res_i;
          rs2_d      = ex_rs2_i;
          opcode_d   = ex_opcode_i;
          funct3_d   = ex_funct3_i;
          rd_d       = ex_rd_i;
          pc_d       = ex_pc_i;
          misalign_d = 1'b0;
          if (!ex_is_mem) begin
            wb_data_d = ex_res_i;
            wb_we_d   = writes_rd(ex_opcode_i) && (ex_rd_i != 5'd0);
            state_d   = DONE;
          end else if (al_misalign) begin
            wb_data_d  = '0;
            wb_we_d    = 1'b0;
            misalign_d = 1'b1;
            state_d    = DONE;
          end else begin
            wb_data_d = '0;
            wb_we_d   = 1'b0;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        if (dmem.req_ready) begin
          state_d = is_store_q ? DONE : WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (dmem.rsp_valid) begin
          wb_data_d = al_ld_data;
          wb_we_d   = (rd_q != 5'd0);
          state_d   = DONE;
        end
      end
      DONE: begin
        if (wb_ready_i) begin
          misalign_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr_full = AWIDTH'(res_q);

  assign ex_ready_o     = in_idle;
  assign dmem.req_valid = in_req;
  assign dmem.req_we    = in_req && is_store_q;
  assign dmem.req_addr  = in_req ? {addr_full[AWIDTH-1:2], 2'b00} : '0;
  assign dmem.req_wdata = in_req ? al_wdata : '0;
  assign dmem.req_be    = in_req ? al_be : 4'b0000;

  assign wb_valid_o    = (state_q == DONE);
  assign wb_data_o     = wb_data_q;
  assign wb_we_o       = wb_we_q;
  assign wb_rd_o       = rd_q;
  assign wb_pc_o       = pc_q;
  assign wb_misalign_o = misalign_q;

endmodule
